dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the core MEM stage (port c_*) and an
//  auxiliary master (port a_*: program loader / debug). Fixed core priority with starvation guard for aux,
//  base-address translation, and routing of 1-cycle-latency read data back to the granted owner.
//  Sits between the MEM stage and dmem; MMIO decode (UART/timer) stays upstream and never reaches here.
// PARAMETERS
//  DMEM_BASE     32'h1000_0000  byte address mapped to dmem offset 0; subtracted from the granted address
//  STARVE_LIMIT  4              consecutive denied aux cycles before aux wins one arbitration (1..15)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  c_req      in   1   core access request (valid this cycle)
//  c_we       in   1   core write (1) / read (0)
//  c_addr     in   32  core byte address
//  c_wdata    in   32  core write data
//  c_size     in   3   core access size/type code, passed to dmem unchanged
//  c_gnt      out  1   core request accepted this cycle (combinational)
//  c_stall    out  1   c_req & ~c_gnt; holds the pipeline
//  c_rvalid   out  1   core read data valid (cycle after a granted read)
//  c_rdata    out  32  core read data
//  a_req/a_we/a_addr/a_wdata/a_size  in  1/1/32/32/3  aux request, same meaning as core
//  a_gnt      out  1   aux request accepted this cycle (combinational)
//  a_rvalid   out  1   aux read data valid
//  a_rdata    out  32  aux read data
//  m_wEn      out  1   dmem write enable
//  m_addr     out  32  dmem offset = granted addr - DMEM_BASE (mod 2^32)
//  m_wData    out  32  dmem write data
//  m_size     out  3   dmem size code
//  m_rData    in   32  dmem read data, valid one cycle after address presented
// BEHAVIOUR
//  - Handshake: request accepted in the cycle req&gnt; requester holds req/addr/data until gnt. No queuing.
//  - Arbitration (combinational, one grant max per cycle):
//      a_req only -> a_gnt; c_req only -> c_gnt;
//      both: state PRI_CORE -> c_gnt; state PRI_AUX -> a_gnt.
//  - FSM (registered, reset -> PRI_CORE):
//      PRI_CORE: starve counter (4 bit, reset 0) += 1 each cycle a_req & ~a_gnt (saturates at 15);
//        cleared on a_gnt or ~a_req; when count+1 reaches STARVE_LIMIT -> PRI_AUX next cycle.
//      PRI_AUX: on a_gnt -> PRI_CORE, counter 0; if a_req drops without grant -> PRI_CORE, counter 0.
//  - Mem side: granted port's addr/wdata/size drive m_*; m_wEn = gnt & we of granted port.
//    No grant: m_* follow core inputs, m_wEn = 0.
//  - Read return: owner register (2 bit: none/core/aux, reset none) loads granted port when granted
//    access is a read, else none. Next cycle: c_rvalid = (owner==core), a_rvalid = (owner==aux);
//    c_rdata/a_rdata = m_rData when own rvalid, else 32'h0. Latency: grant cycle N -> rvalid cycle N+1.
//  - Back-to-back: read in N and any access in N+1 both legal; rdata of N still returned in N+1.
//  - Reset outputs: c_rvalid=a_rvalid=0, rdata=0, FSM PRI_CORE, counter 0; gnt/stall/m_* combinational
//    from inputs (m_wEn=0 while rst). Reset mid-read: pending rvalid dropped, no late return.
//    While rst high: c_gnt=a_gnt=0, c_stall=c_req.
//  - Address below DMEM_BASE wraps (modular subtract); range checking is not this block's job.
// TESTING
//  1 Core only: c_req=1,c_we=1,c_addr=0x1000_0010,wdata=0xDEADBEEF -> c_gnt=1, m_wEn=1, m_addr=0x10 same cycle.
//  2 Read latency: core read 0x1000_0010 in N -> c_rvalid=1,c_rdata=0xDEADBEEF in N+1; a_rvalid=0.
//  3 Contention: c_req,a_req held high 10 cycles -> c_gnt cycles 0-3, a_gnt cycle 4, core again from 5.
//  4 Aux drops early: a_req high 2 cycles under contention, then low -> counter 0, no PRI_AUX, core always granted.
//  5 Alternating owners: core read N, aux read N+1 -> c_rvalid in N+1, a_rvalid in N+2, data not crossed.
//  6 rst asserted the cycle after a granted read -> c_rvalid stays 0; after rst, contention restarts at count 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: core has fixed priority, aux gets a
// starvation-guarded turn, addresses are rebased to dmem offsets and read data is routed to its owner.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE    = 32'h1000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_size,
  output logic        c_gnt,
  output logic        c_stall,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [2:0]  a_size,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        m_wEn,
  output logic [31:0] m_addr,
  output logic [31:0] m_wData,
  output logic [2:0]  m_size,
  input  logic [31:0] m_rData
);

  typedef enum logic {PRI_CORE, PRI_AUX} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_AUX} owner_e;

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;

  always_comb begin
    c_gnt = 1'b0;
    a_gnt = 1'b0;
    if (!rst) begin
      if (c_req && (!a_req || state_q == PRI_CORE)) begin
        c_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
    c_stall = c_req & ~c_gnt;
  end

  // With no grant the memory port simply mirrors the core inputs.
  always_comb begin
    m_addr  = c_addr - DMEM_BASE;
    m_wData = c_wdata;
    m_size  = c_size;
    m_wEn   = c_gnt & c_we;
    if (a_gnt) begin
      m_addr  = a_addr - DMEM_BASE;
      m_wData = a_wdata;
      m_size  = a_size;
      m_wEn   = a_we;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      PRI_CORE: begin
        if (a_req && !a_gnt) begin
          starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
          if ({1'b0, starve_q} + 5'd1 >= LIMIT) begin
            state_d = PRI_AUX;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      PRI_AUX: begin
        if (a_gnt || !a_req) begin
          state_d  = PRI_CORE;
          starve_d = 4'd0;
        end
      end
      default: begin
        state_d  = PRI_CORE;
        starve_d = 4'd0;
      end
    endcase

    owner_d = OWN_NONE;
    if (c_gnt && !c_we) begin
      owner_d = OWN_CORE;
    end else if (a_gnt && !a_we) begin
      owner_d = OWN_AUX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PRI_CORE;
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Gating with rst drops a return that was pending when reset arrived.
  always_comb begin
    c_rvalid = (owner_q == OWN_CORE) && !rst;
    a_rvalid = (owner_q == OWN_AUX) && !rst;
    c_rdata  = c_rvalid ? m_rData : 32'h0;
    a_rdata  = a_rvalid ? m_rData : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural grant/memory model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, a_req, a_we;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic [2:0]  c_size, a_size;
  logic        c_gnt, c_stall, c_rvalid, a_gnt, a_rvalid, m_wEn;
  logic [31:0] c_rdata, a_rdata, m_addr, m_wData;
  logic [2:0]  m_size;
  logic [31:0] m_rData = 32'h0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DMEM_BASE(BASE), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .m_wEn(m_wEn), .m_addr(m_addr), .m_wData(m_wData), .m_size(m_size), .m_rData(m_rData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill_value(logic [31:0] off);
    return off ^ 32'hA5A5_0000;
  endfunction

  // dmem stand-in, driven only by the arbiter's memory-side outputs
  logic [31:0] stub_mem [logic [31:0]];
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = stub_mem.exists(m_addr) ? stub_mem[m_addr] : fill_value(m_addr);
    if (m_wEn) stub_mem[m_addr] = m_wData;
    m_rData <= rd;
  end

  // Model: 0 = nobody, 1 = core, 2 = aux.
  function automatic int exp_grant(logic r, logic cr, logic ar, int streak);
    if (r) return 0;
    if (cr && ar) return (streak >= LIMIT) ? 2 : 1;
    if (cr) return 1;
    if (ar) return 2;
    return 0;
  endfunction

  logic [31:0] mdl_mem [logic [31:0]];
  int          mdl_streak = 0;
  int          pend_who = 0;
  logic [31:0] pend_data = 32'h0;

  always @(posedge clk) begin
    int g;
    logic [31:0] off;
    g = exp_grant(rst, c_req, a_req, mdl_streak);
    off = ((g == 2) ? a_addr : c_addr) - BASE;
    pend_who  = 0;
    pend_data = mdl_mem.exists(off) ? mdl_mem[off] : fill_value(off);
    if (g == 1) begin
      if (c_we) mdl_mem[off] = c_wdata; else pend_who = 1;
    end else if (g == 2) begin
      if (a_we) mdl_mem[off] = a_wdata; else pend_who = 2;
    end
    if (rst || !a_req || g == 2) mdl_streak = 0;
    else if (mdl_streak < 15) mdl_streak = mdl_streak + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    logic [31:0] ea;
    g  = exp_grant(rst, c_req, a_req, mdl_streak);
    ea = ((g == 2) ? a_addr : c_addr) - BASE;
    checkOutput("m_c_gnt", {31'b0, c_gnt}, {31'b0, g == 1});
    checkOutput("m_a_gnt", {31'b0, a_gnt}, {31'b0, g == 2});
    checkOutput("m_c_stall", {31'b0, c_stall}, {31'b0, c_req && g != 1});
    checkOutput("m_m_addr", m_addr, ea);
    checkOutput("m_m_wData", m_wData, (g == 2) ? a_wdata : c_wdata);
    checkOutput("m_m_size", {29'b0, m_size}, {29'b0, (g == 2) ? a_size : c_size});
    checkOutput("m_m_wEn", {31'b0, m_wEn}, {31'b0, (g == 1 && c_we) || (g == 2 && a_we)});
    checkOutput("m_c_rvalid", {31'b0, c_rvalid}, {31'b0, pend_who == 1 && !rst});
    checkOutput("m_a_rvalid", {31'b0, a_rvalid}, {31'b0, pend_who == 2 && !rst});
    checkOutput("m_c_rdata", c_rdata, (pend_who == 1 && !rst) ? pend_data : 32'h0);
    checkOutput("m_a_rdata", a_rdata, (pend_who == 2 && !rst) ? pend_data : 32'h0);
  end

  // One cycle per call; returns at the negedge so callers can check literals.
  task automatic applyStimulus(input logic r,
                               input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad);
    @(posedge clk);
    #1;
    rst = r;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, BASE, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = BASE; c_wdata = 32'h0; c_size = 3'b010;
    a_req = 1'b0; a_we = 1'b0; a_addr = BASE; a_wdata = 32'h0; a_size = 3'b101;

    // Reset: no grants, core stalls, no read return
    applyStimulus(1'b1, 1'b1, 1'b0, BASE, 32'h0, 1'b1, 1'b1, BASE, 32'h0);
    checkOutput("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
    checkOutput("rst_c_stall", {31'b0, c_stall}, 32'd1);
    checkOutput("rst_m_wEn", {31'b0, m_wEn}, 32'd0);
    checkOutput("rst_c_rvalid", {31'b0, c_rvalid}, 32'd0);

    // Core-only write
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, BASE, 32'h0);
    checkOutput("t1_c_gnt", {31'b0, c_gnt}, 32'd1);
    checkOutput("t1_m_wEn", {31'b0, m_wEn}, 32'd1);
    checkOutput("t1_m_addr", m_addr, 32'h0000_0010);

    // Read latency
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 1'b0, BASE, 32'h0);
    idle();
    checkOutput("t2_c_rvalid", {31'b0, c_rvalid}, 32'd1);
    checkOutput("t2_c_rdata", c_rdata, 32'hDEAD_BEEF);
    checkOutput("t2_a_rvalid", {31'b0, a_rvalid}, 32'd0);

    // Sustained contention: aux wins on the fifth cycle of each starvation window
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h100, 32'h0, 1'b1, 1'b0, BASE + 32'h200, 32'h0);
      checkOutput("t3_a_gnt", {31'b0, a_gnt}, {31'b0, i == 4 || i == 9});
      checkOutput("t3_c_gnt", {31'b0, c_gnt}, {31'b0, !(i == 4 || i == 9)});
    end

    // Aux gives up early: core keeps every grant
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h40, 32'h0, i < 2, 1'b0, BASE + 32'h80, 32'h0);
      checkOutput("t4_c_gnt", {31'b0, c_gnt}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h40, 32'h0, 1'b1, 1'b0, BASE + 32'h80, 32'h0);
      checkOutput("t4_restart_c_gnt", {31'b0, c_gnt}, 32'd1);
    end
    idle();

    // Alternating owners: data must not cross
    applyStimulus(1'b0, 1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 1'b0, BASE, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 32'h1000_0020, 32'h0);
    checkOutput("t5_c_rvalid", {31'b0, c_rvalid}, 32'd1);
    checkOutput("t5_c_rdata", c_rdata, 32'hDEAD_BEEF);
    checkOutput("t5_a_rdata0", a_rdata, 32'h0);
    idle();
    checkOutput("t5_a_rvalid", {31'b0, a_rvalid}, 32'd1);
    checkOutput("t5_a_rdata", a_rdata, 32'h1234_5678);
    checkOutput("t5_c_rvalid_off", {31'b0, c_rvalid}, 32'd0);

    // Address below the base wraps
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 1'b0, BASE, 32'h0);
    checkOutput("wrap_m_addr", m_addr, 32'hF000_0004);

    // Reset right after a granted read, with one denied aux cycle already counted
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 1'b0, BASE + 32'h300, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, BASE, 32'h0);
    checkOutput("t6_c_rvalid_rst", {31'b0, c_rvalid}, 32'd0);
    checkOutput("t6_c_rdata_rst", c_rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 1'b1, 1'b0, BASE + 32'h300, 32'h0);
      if (i == 0) checkOutput("t6_no_late_rvalid", {31'b0, c_rvalid}, 32'd0);
      checkOutput("t6_a_gnt", {31'b0, a_gnt}, {31'b0, i == 4});
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
